// File: rtl/pmem_pkg.sv
// ---------------------------------------------------------------------------
// pmem_pkg
// Shared definitions for the program/data memory front end. The state
// encoding is also used by the GPU memory controller, so the values are
// fixed and must not be renumbered.
// ---------------------------------------------------------------------------
package pmem_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'b000,
    READ_WAITING   = 3'b010,
    WRITE_WAITING  = 3'b011,
    READ_RELAYING  = 3'b100,
    WRITE_RELAYING = 3'b101
  } pmem_state_t;

endpackage

// File: rtl/pmem_rr_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority selector. Starting at ptr and wrapping
// modulo N, it returns the first index whose req bit is set.
//   req   : request vector, one bit per requester
//   ptr   : index that currently has the highest priority
//   found : at least one request is set
//   idx   : index of the winning requester (0 when found is low)
// ---------------------------------------------------------------------------
module rr_priority_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;

  // Walk the requesters in priority order ptr, ptr+1, ... and keep the
  // first hit. The extra sum bit lets the wrap work for any N, not just
  // powers of two.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pmem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// pmem_rr_arbiter
// Shares one external memory port between NUM_CONSUMERS fetchers/LSUs with
// round-robin fairness. One transaction is outstanding at a time. Consumers
// use a relay handshake: hold valid until ready, drop valid, then the
// arbiter drops ready.
//   clk, reset                 : clock, synchronous active-high reset
//   consumer_read_*            : per-consumer read request/response (flat)
//   consumer_write_*           : per-consumer write request/ack (flat)
//   mem_read_*, mem_write_*    : single external memory port
//   busy                       : a transaction is in progress
//   grant_id                   : consumer being served (held when idle)
//   timeout_error              : sticky, memory failed to answer in time
// ---------------------------------------------------------------------------
module pmem_rr_arbiter
  import pmem_pkg::*;
#(
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 16,
  parameter int NUM_CONSUMERS  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             consumer_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]             consumer_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]             consumer_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   consumer_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]             consumer_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready,
  output logic                                 busy,
  output logic [$clog2(NUM_CONSUMERS)-1:0]     grant_id,
  output logic                                 timeout_error
);

  localparam int IDX_W = $clog2(NUM_CONSUMERS);
  localparam int WD_W  = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  pmem_state_t              state;
  logic [IDX_W-1:0]         rr_ptr;
  logic [WD_W-1:0]          watchdog;
  logic [NUM_CONSUMERS-1:0] req;
  logic                     pick_found;
  logic [IDX_W-1:0]         pick_idx;
  logic                     stalled;

  assign req  = consumer_read_valid | consumer_write_valid;
  assign busy = (state != IDLE);

  // A wait state whose memory response has not arrived this cycle.
  assign stalled = ((state == READ_WAITING)  && !mem_read_ready) ||
                   ((state == WRITE_WAITING) && !mem_write_ready);

  rr_priority_pick #(
    .N     (NUM_CONSUMERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Main transaction FSM. Address/data are captured at grant so consumers
  // may change them while waiting. Ready is only ever raised for the
  // granted consumer, and reset drops everything without a relay.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      rr_ptr               <= '0;
      grant_id             <= '0;
      mem_read_valid       <= 1'b0;
      mem_read_address     <= '0;
      mem_write_valid      <= 1'b0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            rr_ptr   <= (pick_idx == IDX_W'(NUM_CONSUMERS - 1)) ? '0 : pick_idx + IDX_W'(1);
            if (consumer_read_valid[pick_idx]) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= consumer_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
              state            <= READ_WAITING;
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= consumer_write_address[pick_idx*ADDR_BITS +: ADDR_BITS];
              mem_write_data    <= consumer_write_data[pick_idx*DATA_BITS +: DATA_BITS];
              state             <= WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (mem_read_ready) begin
            mem_read_valid                                   <= 1'b0;
            consumer_read_ready[grant_id]                    <= 1'b1;
            consumer_read_data[grant_id*DATA_BITS +: DATA_BITS] <= mem_read_data;
            state                                            <= READ_RELAYING;
          end
        end
        WRITE_WAITING: begin
          if (mem_write_ready) begin
            mem_write_valid                <= 1'b0;
            consumer_write_ready[grant_id] <= 1'b1;
            state                          <= WRITE_RELAYING;
          end
        end
        READ_RELAYING: begin
          if (!consumer_read_valid[grant_id]) begin
            consumer_read_ready[grant_id] <= 1'b0;
            state                         <= IDLE;
          end
        end
        WRITE_RELAYING: begin
          if (!consumer_write_valid[grant_id]) begin
            consumer_write_ready[grant_id] <= 1'b0;
            state                          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Watchdog: counts stalled wait cycles of the current transaction and
  // saturates at the limit. Clearing while idle is equivalent to clearing
  // at grant. The error flag never clears except by reset, and the request
  // is left waiting rather than aborted.
  always_ff @(posedge clk) begin
    if (reset) begin
      watchdog      <= '0;
      timeout_error <= 1'b0;
    end else if (state == IDLE) begin
      watchdog <= '0;
    end else if ((TIMEOUT_CYCLES != 0) && stalled && (watchdog != WD_MAX)) begin
      watchdog <= watchdog + WD_W'(1);
      if (watchdog == WD_LAST) begin
        timeout_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pmem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pmem_rr_arbiter
// Directed, table-driven bench for pmem_rr_arbiter (4 consumers, 8-bit
// address, 16-bit data, watchdog limit 4). Consumer i addresses are laid
// out in flat vectors at [i*W +: W].
// ---------------------------------------------------------------------------
module tb_pmem_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rv, wv;
  logic [31:0] raddr, waddr;
  logic [63:0] wdata;
  logic [3:0]  rready, wready;
  logic [63:0] rdata;
  logic        mrv, mrr, mwv, mwr;
  logic [7:0]  mraddr, mwaddr;
  logic [15:0] mrdata, mwdata;
  logic        busy, terr;
  logic [1:0]  gid;

  int numChecks   = 0;
  int numFailures = 0;

  pmem_rr_arbiter #(
    .ADDR_BITS      (8),
    .DATA_BITS      (16),
    .NUM_CONSUMERS  (4),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (raddr),
    .consumer_read_ready    (rready),
    .consumer_read_data     (rdata),
    .consumer_write_valid   (wv),
    .consumer_write_address (waddr),
    .consumer_write_data    (wdata),
    .consumer_write_ready   (wready),
    .mem_read_valid         (mrv),
    .mem_read_address       (mraddr),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrdata),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwaddr),
    .mem_write_data         (mwdata),
    .mem_write_ready        (mwr),
    .busy                   (busy),
    .grant_id               (gid),
    .timeout_error          (terr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rv, wv;
    logic        mrr;
    logic [15:0] mrd;
    logic        mwr;
    logic        emrv, emwv;
    logic [7:0]  eraddr, ewaddr;
    logic [15:0] ewdata;
    logic [3:0]  erready, ewready;
    logic [63:0] erdata;
    logic        ebusy;
    logic [1:0]  egid;
  } vec_t;

  vec_t vecs[24];

  // Drive one cycle of inputs, take the clock edge, then settle 1ns past it
  // so outputs are sampled away from the edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] w,
                               input logic mr, input logic [15:0] md, input logic mw);
    rv     = r;
    wv     = w;
    mrr    = mr;
    mrdata = md;
    mwr    = mw;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numFailures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " mrv"},    64'(mrv),    64'h0);
    checkOutput({tag, " mwv"},    64'(mwv),    64'h0);
    checkOutput({tag, " mraddr"}, 64'(mraddr), 64'h0);
    checkOutput({tag, " mwaddr"}, 64'(mwaddr), 64'h0);
    checkOutput({tag, " mwdata"}, 64'(mwdata), 64'h0);
    checkOutput({tag, " rready"}, 64'(rready), 64'h0);
    checkOutput({tag, " wready"}, 64'(wready), 64'h0);
    checkOutput({tag, " rdata"},  rdata,       64'h0);
    checkOutput({tag, " busy"},   64'(busy),   64'h0);
    checkOutput({tag, " gid"},    64'(gid),    64'h0);
    checkOutput({tag, " terr"},   64'(terr),   64'h0);
  endtask

  initial begin
    // Fairness sweep (0,1,2,3,0), ignored memory ready while relaying,
    // then read-before-write for consumer 1 with consumer 0 writing in between.
    vecs[0]  = '{4'b1111, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h1F, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'h0000_0000_0000_0000, 1'b1, 2'd0};
    vecs[1]  = '{4'b1111, 4'b0000, 1'b1, 16'hA000, 1'b0, 1'b0, 1'b0, 8'h1F, 8'h00, 16'h0000, 4'b0001, 4'b0000, 64'h0000_0000_0000_A000, 1'b1, 2'd0};
    vecs[2]  = '{4'b1110, 4'b0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'h1F, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'h0000_0000_0000_A000, 1'b0, 2'd0};
    vecs[3]  = '{4'b1111, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'h0000_0000_0000_A000, 1'b1, 2'd1};
    vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 16'hA001, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 16'h0000, 4'b0010, 4'b0000, 64'h0000_0000_A001_A000, 1'b1, 2'd1};
    vecs[5]  = '{4'b1101, 4'b0000, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'h0000_0000_A001_A000, 1'b0, 2'd1};
    vecs[6]  = '{4'b1111, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h21, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'h0000_0000_A001_A000, 1'b1, 2'd2};
    vecs[7]  = '{4'b1111, 4'b0000, 1'b1, 16'hA002, 1'b0, 1'b0, 1'b0, 8'h21, 8'h00, 16'h0000, 4'b0100, 4'b0000, 64'h0000_A002_A001_A000, 1'b1, 2'd2};
    vecs[8]  = '{4'b1011, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h21, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'h0000_A002_A001_A000, 1'b0, 2'd2};
    vecs[9]  = '{4'b1111, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h22, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'h0000_A002_A001_A000, 1'b1, 2'd3};
    vecs[10] = '{4'b1111, 4'b0000, 1'b1, 16'hA003, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 16'h0000, 4'b1000, 4'b0000, 64'hA003_A002_A001_A000, 1'b1, 2'd3};
    vecs[11] = '{4'b0111, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h22, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'hA003_A002_A001_A000, 1'b0, 2'd3};
    vecs[12] = '{4'b1111, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h1F, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'hA003_A002_A001_A000, 1'b1, 2'd0};
    vecs[13] = '{4'b1111, 4'b0000, 1'b1, 16'hA004, 1'b0, 1'b0, 1'b0, 8'h1F, 8'h00, 16'h0000, 4'b0001, 4'b0000, 64'hA003_A002_A001_A004, 1'b1, 2'd0};
    vecs[14] = '{4'b1110, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h1F, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'hA003_A002_A001_A004, 1'b0, 2'd0};
    vecs[15] = '{4'b0010, 4'b0010, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h20, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'hA003_A002_A001_A004, 1'b1, 2'd1};
    vecs[16] = '{4'b0010, 4'b0010, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 16'h0000, 4'b0010, 4'b0000, 64'hA003_A002_5555_A004, 1'b1, 2'd1};
    vecs[17] = '{4'b0000, 4'b0011, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h20, 8'h00, 16'h0000, 4'b0000, 4'b0000, 64'hA003_A002_5555_A004, 1'b0, 2'd1};
    vecs[18] = '{4'b0000, 4'b0011, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h20, 8'h2F, 16'hBEEE, 4'b0000, 4'b0000, 64'hA003_A002_5555_A004, 1'b1, 2'd0};
    vecs[19] = '{4'b0000, 4'b0011, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h20, 8'h2F, 16'hBEEE, 4'b0000, 4'b0001, 64'hA003_A002_5555_A004, 1'b1, 2'd0};
    vecs[20] = '{4'b0000, 4'b0010, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h20, 8'h2F, 16'hBEEE, 4'b0000, 4'b0000, 64'hA003_A002_5555_A004, 1'b0, 2'd0};
    vecs[21] = '{4'b0000, 4'b0010, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'h20, 8'h30, 16'hBEEF, 4'b0000, 4'b0000, 64'hA003_A002_5555_A004, 1'b1, 2'd1};
    vecs[22] = '{4'b0000, 4'b0010, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 8'h20, 8'h30, 16'hBEEF, 4'b0000, 4'b0010, 64'hA003_A002_5555_A004, 1'b1, 2'd1};
    vecs[23] = '{4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'h20, 8'h30, 16'hBEEF, 4'b0000, 4'b0000, 64'hA003_A002_5555_A004, 1'b0, 2'd1};

    reset  = 1'b1;
    rv     = '0;
    wv     = '0;
    mrr    = 1'b0;
    mrdata = '0;
    mwr    = 1'b0;
    raddr  = 32'h2221_201F;
    waddr  = 32'h3231_302F;
    wdata  = 64'hBEF1_BEF0_BEEF_BEEE;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    // Table-driven section
    for (int i = 0; i < 24; i++) begin
      applyStimulus(vecs[i].rv, vecs[i].wv, vecs[i].mrr, vecs[i].mrd, vecs[i].mwr);
      checkOutput($sformatf("v%0d mrv", i),    64'(mrv),    64'(vecs[i].emrv));
      checkOutput($sformatf("v%0d mwv", i),    64'(mwv),    64'(vecs[i].emwv));
      checkOutput($sformatf("v%0d mraddr", i), 64'(mraddr), 64'(vecs[i].eraddr));
      checkOutput($sformatf("v%0d mwaddr", i), 64'(mwaddr), 64'(vecs[i].ewaddr));
      checkOutput($sformatf("v%0d mwdata", i), 64'(mwdata), 64'(vecs[i].ewdata));
      checkOutput($sformatf("v%0d rready", i), 64'(rready), 64'(vecs[i].erready));
      checkOutput($sformatf("v%0d wready", i), 64'(wready), 64'(vecs[i].ewready));
      checkOutput($sformatf("v%0d rdata", i),  rdata,       vecs[i].erdata);
      checkOutput($sformatf("v%0d busy", i),   64'(busy),   64'(vecs[i].ebusy));
      checkOutput($sformatf("v%0d gid", i),    64'(gid),    64'(vecs[i].egid));
    end

    // Single read: consumer 2 at 0x10; its address changes while waiting
    // and must be ignored. rr_ptr is 2 here.
    raddr = 32'h2210_201F;
    applyStimulus(4'b0100, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("rd issue mrv",   64'(mrv),    64'h1);
    checkOutput("rd issue addr",  64'(mraddr), 64'h10);
    checkOutput("rd issue gid",   64'(gid),    64'h2);
    raddr = 32'h2277_201F;
    applyStimulus(4'b0100, 4'b0000, 1'b1, 16'h1234, 1'b0);
    checkOutput("rd resp rready", 64'(rready), 64'h4);
    checkOutput("rd resp data",   64'(rdata[47:32]), 64'h1234);
    checkOutput("rd resp addr",   64'(mraddr), 64'h10);
    checkOutput("rd resp mrv",    64'(mrv),    64'h0);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("rd hold rready", 64'(rready), 64'h4);
    checkOutput("rd hold busy",   64'(busy),   64'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("rd done rready", 64'(rready), 64'h0);
    checkOutput("rd done busy",   64'(busy),   64'h0);
    checkOutput("rd done gid",    64'(gid),    64'h2);
    checkOutput("rd done data",   64'(rdata[47:32]), 64'h1234);
    checkOutput("rd done terr",   64'(terr),   64'h0);

    // Wrap: rr_ptr is 3, only consumer 0 requests; then 0,1,2 together
    // must go to consumer 1, proving rr_ptr moved to 1.
    applyStimulus(4'b0001, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("wrap gid",  64'(gid),    64'h0);
    checkOutput("wrap addr", 64'(mraddr), 64'h1F);
    applyStimulus(4'b0001, 4'b0000, 1'b1, 16'h0BAD, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
    applyStimulus(4'b0111, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("wrap next gid", 64'(gid), 64'h1);
    applyStimulus(4'b0111, 4'b0000, 1'b1, 16'h0ACE, 1'b0);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);

    // Watchdog: consumer 3 reads, memory stays silent for four wait cycles.
    applyStimulus(4'b1000, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("wd grant gid", 64'(gid), 64'h3);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(4'b1000, 4'b0000, 1'b0, 16'h0000, 1'b0);
      checkOutput($sformatf("wd wait%0d terr", i), 64'(terr), 64'h0);
    end
    applyStimulus(4'b1000, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("wd wait4 terr", 64'(terr), 64'h1);
    checkOutput("wd wait4 mrv",  64'(mrv),  64'h1);
    checkOutput("wd wait4 busy", 64'(busy), 64'h1);
    applyStimulus(4'b1000, 4'b0000, 1'b1, 16'hCAFE, 1'b0);
    checkOutput("wd late rready", 64'(rready), 64'h8);
    checkOutput("wd late data",   64'(rdata[63:48]), 64'hCAFE);
    checkOutput("wd late terr",   64'(terr), 64'h1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("wd end busy", 64'(busy), 64'h0);
    checkOutput("wd end terr", 64'(terr), 64'h1);

    // Reset mid-write: consumer 2 write is abandoned; afterwards rr_ptr=0,
    // so requests from 1 and 3 go to consumer 1.
    applyStimulus(4'b0000, 4'b0100, 1'b0, 16'h0000, 1'b0);
    checkOutput("rst write mwv", 64'(mwv), 64'h1);
    checkOutput("rst write gid", 64'(gid), 64'h2);
    reset = 1'b1;
    applyStimulus(4'b0000, 4'b0100, 1'b0, 16'h0000, 1'b0);
    checkAllZero("midreset");
    reset = 1'b0;
    applyStimulus(4'b1010, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("post rst gid",  64'(gid),    64'h1);
    checkOutput("post rst addr", 64'(mraddr), 64'h20);
    applyStimulus(4'b1010, 4'b0000, 1'b1, 16'h7777, 1'b0);
    checkOutput("post rst rready", 64'(rready), 64'h2);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 16'h0000, 1'b0);
    checkOutput("post rst idle", 64'(busy), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFailures);
    $finish;
  end

endmodule
